// File: rtl/mio_mem_responder.sv
// Memory/IO responder for the CPU MIO port: captures one word request, inserts
// WAIT_CYCLES wait states, then answers with a one-cycle MIO_ready pulse.
module mio_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic [31:0] gpio_out
);

  localparam int DATA_W = 32;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {T_RAM, T_GPIO, T_CNT, T_NONE} tgt_t;

  function automatic tgt_t decode(input logic [31:0] a);
    logic [31:0] word_a;
    word_a = {a[31:2], 2'b00};
    if (a[31:28] == 4'h0)       return T_RAM;
    else if (word_a == GPIO_ADDR) return T_GPIO;
    else if (word_a == CNT_ADDR)  return T_CNT;
    return T_NONE;
  endfunction

  state_t              state;
  logic [3:0]          wcnt;
  logic [DATA_W-1:0]   counter;
  logic [31:0]         addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic                wr_p0;
  logic [DATA_W-1:0]   ram [2**ADDR_W];

  logic [31:0]         req_addr;
  logic                req_wr;
  logic                enter_ack;
  logic [DATA_W-1:0]   rd_data;
  logic                commit_ram;

  // In IDLE the request is still on the bus; afterwards it lives in the holding registers.
  assign req_addr   = (state == S_IDLE) ? Addr_in : addr_p0;
  assign req_wr     = (state == S_IDLE) ? mem_w   : wr_p0;
  assign enter_ack  = ((state == S_IDLE) && CPU_MIO && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (wcnt == 4'd0));
  assign commit_ram = (state == S_ACK) && wr_p0 && (decode(addr_p0) == T_RAM);

  always_comb begin
    rd_data = '0;
    case (decode(req_addr))
      T_RAM:   rd_data = ram[req_addr[ADDR_W+1:2]];
      T_GPIO:  rd_data = gpio_out;
      T_CNT:   rd_data = counter;
      default: rd_data = '0;
    endcase
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && CPU_MIO) begin
      addr_p0  <= Addr_in;
      wdata_p0 <= Data_in;
      wr_p0    <= mem_w;
    end
  end

  // Commit stage: a reset during ACK must suppress the write
  always_ff @(posedge clk) begin
    if (!reset && commit_ram)
      ram[addr_p0[ADDR_W+1:2]] <= wdata_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      counter   <= '0;
      MIO_ready <= 1'b0;
      Data_out  <= '0;
      gpio_out  <= '0;
    end else begin
      counter   <= counter + 1'b1;
      MIO_ready <= enter_ack;
      Data_out  <= (enter_ack && !req_wr) ? rd_data : '0;
      case (state)
        S_IDLE: begin
          if (CPU_MIO) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_ACK;
            end else begin
              wcnt  <= WAIT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wcnt != 4'd0) wcnt  <= wcnt - 4'd1;
          else              state <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
          if (wr_p0 && (decode(addr_p0) == T_GPIO))
            gpio_out <= wdata_p0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
